// File: rtl/glyph_plotter.sv
// rtl/glyph_plotter.sv - renders one 5x6 letter glyph into a cell of a multi-row text grid
//
// Optional feature macro: GLYPH_PLOTTER_ERASE_EN (clear bits also plot in bg_colour).
//
// Ports:
//   clk         in   system clock
//   resetn      in   synchronous, active-high reset
//   start       in   request strobe, accepted when start && !busy
//   char_code   in   1..26 = a..z, anything else is blank
//   cell_idx    in   linear cell index (row = idx / NUM_COLS, col = idx % NUM_COLS)
//   fg_colour   in   colour for set glyph bits
//   bg_colour   in   colour for clear glyph bits (erase build only)
//   busy        out  request in progress
//   done        out  one-cycle pulse at request end
//   err         out  valid with done; cell index out of range
//   plot        out  pixel write valid
//   plot_x      out  pixel x
//   plot_y      out  pixel y
//   plot_colour out  pixel colour
//   plot_ready  in   adapter accepts the pixel when plot && plot_ready
module glyph_plotter #(
   parameter int NUM_COLS   = 10,
   parameter int NUM_ROWS   = 1,
   parameter int X_ORIGIN   = 17,
   parameter int Y_ORIGIN   = 95,
   parameter int CELL_PITCH = 14,
   parameter int ROW_PITCH  = 8,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int COLOUR_W   = 3,
   parameter int IDX_W      = 5
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [4:0]          char_code,
   input  logic [IDX_W-1:0]    cell_idx,
   input  logic [COLOUR_W-1:0] fg_colour,
   input  logic [COLOUR_W-1:0] bg_colour,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                plot,
   output logic [X_W-1:0]      plot_x,
   output logic [Y_W-1:0]      plot_y,
   output logic [COLOUR_W-1:0] plot_colour,
   input  logic                plot_ready
);

   typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

   state_t              state, state_nx;
   logic [4:0]          char_l;
   logic [IDX_W-1:0]    idx_l;
   logic [COLOUR_W-1:0] fg_l, bg_l;
   logic [29:0]         glyph;      // shifts left; bit 29 is always the current pixel
   logic [2:0]          col_cnt, row_cnt;
   logic [X_W-1:0]      base_x;
   logic [Y_W-1:0]      base_y;
   logic                err_l;
   logic                idx_ok, pix_on, advance, last_bit;
   logic [31:0]         cell_row, cell_col;

   // 5 wide x 6 high, row-major, bit 29 = top-left
   function automatic logic [29:0] font(input logic [4:0] code);
      case (code)
         5'd1:    font = 30'b011101000110001111111000110001;
         5'd2:    font = 30'b111101000111110100011000111110;
         5'd3:    font = 30'b011111000010000100001000001111;
         5'd4:    font = 30'b111101000110001100011000111110;
         5'd5:    font = 30'b111111000011110100001000011111;
         5'd6:    font = 30'b111111000011110100001000010000;
         5'd7:    font = 30'b011111000010011100011000101111;
         5'd8:    font = 30'b100011000111111100011000110001;
         5'd9:    font = 30'b111110010000100001000010011111;
         5'd10:   font = 30'b001110001000010000101001001100;
         5'd11:   font = 30'b100011001011100100101000110001;
         5'd12:   font = 30'b100001000010000100001000011111;
         5'd13:   font = 30'b100011101110101100011000110001;
         5'd14:   font = 30'b100011100110101100111000110001;
         5'd15:   font = 30'b011101000110001100011000101110;
         5'd16:   font = 30'b111101000110001111101000010000;
         5'd17:   font = 30'b011101000110001101011001001101;
         5'd18:   font = 30'b111101000110001111101001010001;
         5'd19:   font = 30'b011111000001110000010000111110;
         5'd20:   font = 30'b111110010000100001000010000100;
         5'd21:   font = 30'b100011000110001100011000101110;
         5'd22:   font = 30'b100011000110001100010101000100;
         5'd23:   font = 30'b100011000110001101011101110001;
         5'd24:   font = 30'b100010101000100001000101010001;
         5'd25:   font = 30'b100010101000100001000010000100;
         5'd26:   font = 30'b111110001000100010001000011111;
         default: font = 30'd0;
      endcase
   endfunction

   always_comb begin
      cell_row = 32'(idx_l) / 32'(NUM_COLS);
      cell_col = 32'(idx_l) % 32'(NUM_COLS);
      idx_ok   = 32'(idx_l) < 32'(NUM_COLS * NUM_ROWS);
`ifdef GLYPH_PLOTTER_ERASE_EN
      pix_on   = 1'b1;
`else
      pix_on   = glyph[29];
`endif
      advance  = !pix_on || plot_ready;
      last_bit = (row_cnt == 3'd5) && (col_cnt == 3'd4);
   end

   always_comb begin
      state_nx    = state;
      busy        = (state != IDLE);
      done        = 1'b0;
      err         = 1'b0;
      plot        = 1'b0;
      plot_colour = '0;
      plot_x      = base_x + X_W'(col_cnt);
      plot_y      = base_y + Y_W'(row_cnt);
      case (state)
         IDLE: if (start) state_nx = LOAD;
         LOAD: state_nx = idx_ok ? SCAN : DONE;
         SCAN: begin
            plot = pix_on;
            if (pix_on) plot_colour = glyph[29] ? fg_l : bg_l;
            if (advance && last_bit) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            err      = err_l;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state   <= IDLE;
         char_l  <= '0;
         idx_l   <= '0;
         fg_l    <= '0;
         bg_l    <= '0;
         glyph   <= '0;
         col_cnt <= '0;
         row_cnt <= '0;
         base_x  <= '0;
         base_y  <= '0;
         err_l   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               char_l <= char_code;
               idx_l  <= cell_idx;
               fg_l   <= fg_colour;
               bg_l   <= bg_colour;
            end
            LOAD: begin
               glyph   <= font(char_l);
               base_x  <= X_W'(32'(X_ORIGIN) + cell_col * 32'(CELL_PITCH));
               base_y  <= Y_W'(32'(Y_ORIGIN) + cell_row * 32'(ROW_PITCH));
               col_cnt <= '0;
               row_cnt <= '0;
               err_l   <= !idx_ok;
            end
            SCAN: if (advance && !last_bit) begin
               glyph <= {glyph[28:0], 1'b0};
               if (col_cnt == 3'd4) begin
                  col_cnt <= '0;
                  row_cnt <= row_cnt + 3'd1;
               end else begin
                  col_cnt <= col_cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_glyph_plotter.sv
// tb/tb_glyph_plotter.sv - directed self-checking bench for glyph_plotter
module tb_glyph_plotter;

   logic       clk = 1'b0;
   logic       resetn, start, plot_ready;
   logic [4:0] char_code, cell_idx;
   logic [2:0] fg_colour, bg_colour;
   logic       busy, done, err, plot;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [2:0] plot_colour;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef GLYPH_PLOTTER_ERASE_EN
   localparam bit ERASE = 1'b1;
`else
   localparam bit ERASE = 1'b0;
`endif

   localparam logic [29:0] BMP_A = 30'b011101000110001111111000110001;
   localparam logic [29:0] BMP_T = 30'b111110010000100001000010000100;
   localparam logic [29:0] BMP_0 = 30'd0;

   always #5 clk = ~clk;

   glyph_plotter dut (
      .clk(clk), .resetn(resetn), .start(start), .char_code(char_code),
      .cell_idx(cell_idx), .fg_colour(fg_colour), .bg_colour(bg_colour),
      .busy(busy), .done(done), .err(err), .plot(plot), .plot_x(plot_x),
      .plot_y(plot_y), .plot_colour(plot_colour), .plot_ready(plot_ready)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one request starting just after a clock edge; returns with the bench
   // in the cycle after DONE (IDLE), so a follow-on start is legal immediately.
   task automatic run_req(input logic [4:0] ch, input logic [4:0] idx,
                          input logic [2:0] fg, input logic [2:0] bg,
                          input logic [29:0] bmp, input int bx, input int by,
                          input bit toggle, input bit valid,
                          output int nplots, output int done_cyc,
                          output logic [17:0] first_px, output logic [17:0] last_px);
      logic [17:0] exp_q[$];
      logic [17:0] held, obs;
      logic [29:0] bits;
      bit          held_v, seen_done, on;
      int          cyc, exp_done;

      bits = bmp;
      exp_done = 2;
      if (valid) begin
         for (int b = 0; b < 30; b++) begin
            on = bits[29-b] || ERASE;
            if (on) begin
               exp_q.push_back({8'(bx + b % 5), 7'(by + b / 5), bits[29-b] ? fg : bg});
               while (toggle && (exp_done % 2) == 0) exp_done++;
            end
            exp_done++;
         end
      end

      char_code = ch; cell_idx = idx; fg_colour = fg; bg_colour = bg;
      start = 1'b1;
      plot_ready = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1;
      chk("busy_cycle1", {31'd0, busy}, 32'd1);

      nplots = 0; held_v = 1'b0; seen_done = 1'b0; done_cyc = -1;
      first_px = '0; last_px = '0; held = '0;
      while (cyc < 200 && !seen_done) begin
         plot_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         obs = {plot_x, plot_y, plot_colour};
         if (held_v) chk("stall_hold", {13'd0, plot, obs}, {13'd0, 1'b1, held});
         held_v = 1'b0;
         if (plot) begin
            if (plot_ready) begin
               if (nplots < exp_q.size()) chk("pixel", {14'd0, obs}, {14'd0, exp_q[nplots]});
               if (nplots == 0) first_px = obs;
               last_px = obs;
               nplots++;
            end else begin
               held_v = 1'b1;
               held = obs;
            end
         end
         if (done) begin
            seen_done = 1'b1;
            done_cyc = cyc;
            chk("err_at_done", {31'd0, err}, {31'd0, !valid});
         end else begin
            tick;
            cyc++;
         end
      end
      chk("done_seen", {31'd0, seen_done}, 32'd1);
      chk("done_cycle", done_cyc, exp_done);
      chk("plot_count", nplots, exp_q.size());
      plot_ready = 1'b1;
      tick;
      chk("busy_after_done", {30'd0, busy, done}, 32'd0);
   endtask

   int          np, dc, cnt;
   logic [17:0] fp, lp;

   initial begin
      resetn = 1'b1; start = 1'b0; plot_ready = 1'b1;
      char_code = '0; cell_idx = '0; fg_colour = '0; bg_colour = '0;
      tick; tick;
      resetn = 1'b0;
      chk("reset_outputs", {14'd0, busy, done, err, plot, plot_x, plot_y, plot_colour},
          32'd0);
      tick;
      chk("idle_after_reset", {30'd0, busy, plot}, 32'd0);

      // 'a' at cell 0, ready held high
      run_req(5'd1, 5'd0, 3'b111, 3'b000, BMP_A, 17, 95, 1'b0, 1'b1, np, dc, fp, lp);
      chk("a_count", np, ERASE ? 30 : 16);
      chk("a_first", {14'd0, fp}, {14'd0, ERASE ? 8'd17 : 8'd18, 7'd95, ERASE ? 3'b000 : 3'b111});
      chk("a_last", {14'd0, lp}, {14'd0, 8'd21, 7'd100, 3'b111});
      chk("a_done_32", dc, 32'd32);

      // 't' at cell 2, started the cycle right after the previous DONE
      run_req(5'd20, 5'd2, 3'b001, 3'b000, BMP_T, 45, 95, 1'b0, 1'b1, np, dc, fp, lp);
      chk("t_first", {14'd0, fp}, {14'd0, 8'd45, 7'd95, 3'b001});
      chk("t_last", {14'd0, lp}, {14'd0, 8'd47, 7'd100, 3'b001});
      chk("t_count", np, ERASE ? 30 : 10);

      // 'a' with plot_ready toggling every cycle
      run_req(5'd1, 5'd0, 3'b110, 3'b000, BMP_A, 17, 95, 1'b1, 1'b1, np, dc, fp, lp);
      chk("a_stall_count", np, ERASE ? 30 : 16);
      chk("a_stall_delayed", {31'd0, dc > 32}, 32'd1);

      // out-of-range index, plus a start attempt while busy that must be dropped
      char_code = 5'd5; cell_idx = 5'd10; fg_colour = 3'b111; start = 1'b1;
      tick;
      chk("inv_busy1", {31'd0, busy}, 32'd1);
      char_code = 5'd1; cell_idx = 5'd0;
      tick;
      start = 1'b0;
      chk("inv_done_err_c2", {29'd0, done, err, plot}, 32'd6);
      tick;
      chk("inv_idle_c3", {30'd0, busy, plot}, 32'd0);
      tick;
      chk("busy_start_ignored", {30'd0, busy, plot}, 32'd0);

      // reset during SCAN after the 4th plot
      char_code = 5'd1; cell_idx = 5'd0; fg_colour = 3'b111; start = 1'b1;
      tick;
      start = 1'b0;
      cnt = 0;
      for (int c = 0; c < 40 && cnt < 4; c++) begin
         if (plot) cnt++;
         if (cnt < 4) tick;
      end
      chk("reached_4th_plot", cnt, 32'd4);
      resetn = 1'b1;
      tick;
      chk("mid_reset_outputs", {29'd0, plot, busy, done}, 32'd0);
      resetn = 1'b0;
      tick;
      chk("no_done_after_reset", {30'd0, done, busy}, 32'd0);

      run_req(5'd1, 5'd0, 3'b111, 3'b000, BMP_A, 17, 95, 1'b0, 1'b1, np, dc, fp, lp);
      chk("fresh_a_done_32", dc, 32'd32);

      // blank code: 30 bg plots in erase build, none otherwise
      run_req(5'd0, 5'd0, 3'b101, 3'b010, BMP_0, 17, 95, 1'b0, 1'b1, np, dc, fp, lp);
      chk("blank_count", np, ERASE ? 30 : 0);
      chk("blank_done_32", dc, 32'd32);
      if (ERASE) begin
         chk("blank_first", {14'd0, fp}, {14'd0, 8'd17, 7'd95, 3'b010});
         chk("blank_last", {14'd0, lp}, {14'd0, 8'd21, 7'd100, 3'b010});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/glyph_plotter.md
Name: glyph_plotter

Overview:
- Parametrised successor to the single-row letter fill block: renders one 5x6 letter glyph into any cell of a multi-row text grid on the VGA framebuffer.
- Accepts a start/busy request carrying a character code and a cell index.
- Walks the glyph bitmap and emits per-pixel plot requests, honouring backpressure from the VGA adapter.
- Sits between the game/text controller and the VGA adapter write port.

Parameters:
- NUM_COLS, 10, cells per text row.
- NUM_ROWS, 1, text rows.
- X_ORIGIN, 17, x of the top-left pixel of cell 0.
- Y_ORIGIN, 95, y of the top-left pixel of cell 0.
- CELL_PITCH, 14, x distance between adjacent cells.
- ROW_PITCH, 8, y distance between adjacent rows.
- X_W, 8, plot_x width.
- Y_W, 7, plot_y width.
- COLOUR_W, 3, colour width.
- IDX_W, 5, cell_idx width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock; reset is synchronous and active-high.
- start  in  1  request strobe; accepted when start && !busy.
- char_code  in  5  1..26 = a..z; 0 and 27..31 = blank.
- cell_idx  in  IDX_W  linear cell index, 0-based: row = idx / NUM_COLS, col = idx % NUM_COLS.
- fg_colour  in  COLOUR_W  colour for set glyph bits.
- bg_colour  in  COLOUR_W  colour for clear bits; used only with ERASE_EN.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse at request end.
- err  out  1  high with done if cell_idx >= NUM_COLS*NUM_ROWS.
- plot  out  1  pixel write valid.
- plot_x  out  X_W  pixel x.
- plot_y  out  Y_W  pixel y.
- plot_colour  out  COLOUR_W  pixel colour.
- plot_ready  in  1  adapter accepts the pixel when plot && plot_ready.

Behaviour:
- Reset values: busy=0, done=0, err=0, plot=0, plot_x=0, plot_y=0, plot_colour=0; FSM returns to IDLE.
- Reset mid-request aborts the request; no done pulse is produced.
- Glyph ROM: fixed 5-wide x 6-high, 30 bits per glyph.
  - Bit 29 is the top-left pixel; row-major, MSB first.
  - Bitmaps are the team's standard a..z font (e.g. a = 011101000110001111111000110001).
- FSM states:
  - IDLE: on start && !busy, latch char_code, cell_idx and colours; go to LOAD. Inputs are sampled only at acceptance.
  - LOAD: register the ROM word and base coordinates. If the index is invalid, go to DONE with err=1; otherwise go to SCAN with the bit counter at 0.
  - SCAN: one bit per cycle, row 0 col 0 through row 5 col 4.
    - Set bit: assert plot with plot_x = base_x + c, plot_y = base_y + r, plot_colour = fg. Hold all plot outputs stable until plot_ready, then advance.
    - Clear bit: no plot; advance next cycle.
    - After bit 29 is consumed, go to DONE.
  - DONE: done=1 for exactly one cycle (err valid in the same cycle), busy=0 from the next cycle; return to IDLE.
- Base coordinates: base_x = X_ORIGIN + col*CELL_PITCH, base_y = Y_ORIGIN + row*ROW_PITCH. Sums are truncated to X_W/Y_W (modulo wrap, no saturation).
- Latency, measured from the acceptance edge as cycle 0:
  - busy high in cycle 1.
  - First SCAN cycle is cycle 2.
  - With plot_ready held high: done in cycle 32, busy low in cycle 33.
  - Each stalled cycle adds one.
- start while busy is ignored (not queued).
- A new start is accepted in the cycle after DONE.
- Blank codes scan 30 cycles with no plots, then done with err=0.
- plot never asserts outside SCAN.

Optional Feature:
- Macro: GLYPH_PLOTTER_ERASE_EN.
- Defined: clear bits also plot, with plot_colour = bg_colour; exactly 30 plots per valid request, so the cell is fully overwritten. Blank codes produce 30 bg plots.
- Undefined: clear bits are skipped; bg_colour is ignored.

Test Plan:
- Reset, then start char 1 (a), idx 0, fg 3'b111, plot_ready=1 -> 16 plots; first at (18,95), last at (21,100); done in cycle 32, err=0.
- char 20 (t), idx 2 -> first plot at (45,95); x values confined to 45..49, y to 95..100.
- Repeat the 'a' case with plot_ready toggling 1/0 every cycle -> identical 16-pixel sequence; plot_x/plot_y stable while stalled; done delayed by the stall count.
- char 5, idx 10 (NUM_COLS=10, NUM_ROWS=1) -> no plots; done and err in cycle 2; a second start during busy in another test is ignored.
- Assert resetn during SCAN of 'a' after the 4th plot -> next cycle plot=0, busy=0, no done; a fresh start runs normally.
- With GLYPH_PLOTTER_ERASE_EN and char 0, bg 3'b010 -> 30 plots, all colour 3'b010, covering (17..21, 95..100).
